// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer for the execute stage: one product or
// quotient bit per cycle, with the result held in DONE until E actually advances.
module muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            accept,
    input  logic            flush,
    output logic            done,
    output logic            busy,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [HALF-1:0] MIN_HALF = {1'b1, {(HALF-1){1'b0}}};

    localparam logic [2:0] F_MUL  = 3'b000;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
        return {{HALF{x[HALF-1]}}, x};
    endfunction

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [2:0]       r_funct3;
    logic             r_is_word;
    logic [XLEN-1:0]  r_result;

    logic            w_is_div;
    logic            w_is_signed;
    logic            w_is_mulh;
    logic            w_sa;
    logic            w_sb;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_a_act;
    logic [XLEN-1:0] w_b_act;
    logic [XLEN-1:0] w_a_neg;
    logic [XLEN-1:0] w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_dvd;
    logic [XLEN-1:0] w_special_res;

    logic [XLEN-1:0] w_acc_step;
    logic [XLEN:0]   w_rem_sh;
    logic            w_rem_ge;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_final;

    // Operand preparation and single-cycle special cases, evaluated on the issuing IDLE cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        w_is_div    = funct3[2];
        w_is_signed = funct3[2] & ~funct3[0];
        w_is_mulh   = ~funct3[2] & (funct3[1:0] != 2'b00);

        w_a_act = is_word ? {{HALF{1'b0}}, src_a[HALF-1:0]} : src_a;
        w_b_act = is_word ? {{HALF{1'b0}}, src_b[HALF-1:0]} : src_b;
        w_sa    = is_word ? src_a[HALF-1] : src_a[XLEN-1];
        w_sb    = is_word ? src_b[HALF-1] : src_b[XLEN-1];
        w_a_neg = -w_a_act;
        w_b_neg = -w_b_act;

        w_a_mag = w_a_act;
        w_b_mag = w_b_act;
        if (w_is_signed && w_sa) begin
            w_a_mag = is_word ? {{HALF{1'b0}}, w_a_neg[HALF-1:0]} : w_a_neg;
        end
        if (w_is_signed && w_sb) begin
            w_b_mag = is_word ? {{HALF{1'b0}}, w_b_neg[HALF-1:0]} : w_b_neg;
        end

        // Word dividends sit in the top half so quotient bits fill the low half cleanly.
        w_dvd = is_word ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;

        w_b_zero = (w_b_act == '0);
        w_ovf    = w_is_signed & (is_word
                   ? ((src_a[HALF-1:0] == MIN_HALF) && (src_b[HALF-1:0] == '1))
                   : ((src_a == MIN_FULL) && (src_b == '1)));
        w_special = w_is_mulh | (w_is_div & (w_b_zero | w_ovf));

        w_special_res = '0;
        if (w_is_div && w_b_zero) begin
            w_special_res = funct3[1] ? (is_word ? sext_half(src_a[HALF-1:0]) : src_a) : '1;
        end else if (w_is_div && w_ovf) begin
            w_special_res = funct3[1] ? '0 : (is_word ? sext_half(MIN_HALF) : MIN_FULL);
        end
    end

    // One shift-add step and one restoring-division step per BUSY cycle.
    always_comb begin
        w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

        w_rem_sh   = {r_rem, r_quo[XLEN-1]};
        w_rem_ge   = w_rem_sh[XLEN] | (w_rem_sh[XLEN-1:0] >= r_div);
        w_rem_step = w_rem_ge ? (w_rem_sh[XLEN-1:0] - r_div) : w_rem_sh[XLEN-1:0];
        w_quo_step = {r_quo[XLEN-2:0], w_rem_ge};

        w_quo_fix = r_neg_q ? -w_quo_step : w_quo_step;
        w_rem_fix = r_neg_r ? -w_rem_step : w_rem_step;

        w_sel = '0;
        case (r_funct3)
            F_MUL:          w_sel = w_acc_step;
            F_DIV, F_DIVU:  w_sel = w_quo_fix;
            F_REM, F_REMU:  w_sel = w_rem_fix;
            default:        w_sel = '0;
        endcase

        w_final = r_is_word ? sext_half(w_sel[HALF-1:0]) : w_sel;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // A kill from the pipeline overrides everything, including accept.
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_funct3  <= '0;
            r_is_word <= 1'b0;
            r_result  <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= is_word ? CNT_HALF : CNT_FULL;
                        r_acc     <= '0;
                        r_mcand   <= w_a_act;
                        r_mplier  <= w_b_act;
                        r_rem     <= '0;
                        r_quo     <= w_dvd;
                        r_div     <= w_b_mag;
                        r_neg_q   <= w_is_signed & (w_sa ^ w_sb);
                        r_neg_r   <= w_is_signed & w_sa;
                        r_funct3  <= funct3;
                        r_is_word <= is_word;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt    <= r_cnt - CNT_LAST;
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_step;
                    r_quo    <= w_quo_step;
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset forces done high even if start is still asserted from the frozen E stage.
    assign done   = reset | (r_state == S_DONE) | ((r_state == S_IDLE) & ~start);
    assign busy   = (r_state == S_BUSY);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq: stimulus queues expected results and
// stall lengths from an arithmetic reference model; a monitor pops them as results appear.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;
    localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic        is_word;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        accept;
    logic        flush;
    logic        done;
    logic        busy;
    logic [63:0] result;

    muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .is_word (is_word),
        .src_a   (src_a),
        .src_b   (src_b),
        .accept  (accept),
        .flush   (flush),
        .done    (done),
        .busy    (busy),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b1;
    int          stall_cnt = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from RISC-V M-extension semantics.
    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub, r;
        longint      sa, sb;
        ua = w ? {32'h0, a[31:0]} : a;
        ub = w ? {32'h0, b[31:0]} : b;
        sa = w ? longint'($signed(a[31:0])) : $signed(a);
        sb = w ? longint'($signed(b[31:0])) : $signed(b);
        r  = '0;
        case (f3)
            OP_MUL:  r = ua * ub;
            OP_DIVU: r = (ub == 0) ? '1 : ua / ub;
            OP_REMU: r = (ub == 0) ? ua : ua % ub;
            OP_DIV: begin
                if (sb == 0)                                r = '1;
                else if (!w && a == MIN64 && sb == -1)      r = MIN64;
                else                                        r = sa / sb;
            end
            OP_REM: begin
                if (sb == 0)                                r = sa;
                else if (!w && a == MIN64 && sb == -1)      r = '0;
                else                                        r = sa % sb;
            end
            default: r = '0;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Cycles with done low: the issuing IDLE cycle plus one per iteration, or just one for special cases.
    function automatic int model_lat(input logic [2:0] f3, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub;
        logic        a_min;
        ua    = w ? {32'h0, a[31:0]} : a;
        ub    = w ? {32'h0, b[31:0]} : b;
        a_min = w ? (a[31:0] == 32'h8000_0000) : (a == MIN64);
        if (!f3[2] && f3 != OP_MUL) return 1;
        if (f3[2] && ub == 0) return 1;
        if ((f3 == OP_DIV || f3 == OP_REM) && a_min && (w ? (b[31:0] == '1) : (b == '1))) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_operand(input logic w);
        logic [63:0] v;
        case ($urandom_range(0, 6))
            1:       v = 64'($urandom_range(0, 20));
            2:       v = -64'($urandom_range(1, 20));
            3:       v = '0;
            4:       v = '1;
            5:       v = w ? 64'h0000_0000_8000_0000 : MIN64;
            default: v = {$urandom, $urandom};
        endcase
        if (w) v = {$urandom, v[31:0]};
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepts the result.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int hold);
        exp_t e;
        int   waited;
        e.res = model(f3, w, a, b);
        e.lat = model_lat(f3, w, a, b);
        e.tag = tag;
        sb_q.push_back(e);
        funct3  = f3;
        is_word = w;
        src_a   = a;
        src_b   = b;
        start   = 1'b1;
        accept  = 1'b0;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done && waited < 200);
        if (!done) check({tag, "_timeout"}, 64'(done), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, result, e.res);
            check({tag, "_hold_done"}, 64'(done), 64'd1);
            check({tag, "_hold_busy"}, 64'(busy), 64'd0);
        end
        accept = 1'b1;
        @(posedge clk);
        #1;
        accept   = 1'b0;
        start    = 1'b0;
        last_res = e.res;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                stall_cnt = 0;
            end else if (!done) begin
                stall_cnt++;
            end else if (stall_cnt != 0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: result 0x%h with nothing expected", result);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_result"}, result, e.res);
                    check({e.tag, "_latency"}, 64'(stall_cnt), 64'(e.lat));
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset   = 1'b1;
        start   = 1'b0;
        funct3  = '0;
        is_word = 1'b0;
        src_a   = '0;
        src_b   = '0;
        accept  = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 64'(done), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;

        do_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 0);
        do_op("rem_m7_2",   OP_REM,  1'b0, -64'd7, 64'd2, 0);
        do_op("div_m7_2",   OP_DIV,  1'b0, -64'd7, 64'd2, 0);
        do_op("remw_neg",   OP_REM,  1'b1, 64'h0000_0000_8000_0001, 64'd2, 0);
        do_op("div_by0",    OP_DIV,  1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
        do_op("divw_ovf",   OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        do_op("div_ovf",    OP_DIV,  1'b0, MIN64, '1, 0);
        do_op("mul_basic",  OP_MUL,  1'b0, 64'h0000_0001_0000_0001, 64'd3, 0);
        do_op("mulw_basic", OP_MUL,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 0);
        do_op("mulh_drop",  3'b001,  1'b0, 64'd5, 64'd6, 0);

        do_op("hold", OP_DIVU, 1'b0, 64'd1000, 64'd7, 10);
        @(negedge clk);
        check("hold_after_done", 64'(done), 64'd1);
        check("hold_after_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        mon_en  = 1'b0;
        funct3  = OP_DIVU;
        is_word = 1'b0;
        src_a   = 64'd77777;
        src_b   = 64'd13;
        start   = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        check("flush_idle_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", 64'(busy), 64'd0);
        check("flush_idle_after_done", 64'(done), 64'd1);
        check("flush_idle_result", result, last_res);
        @(posedge clk);
        #1;

        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_busy", 64'(busy), 64'd1);
        check("flush_busy_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_after_done", 64'(done), 64'd1);
        check("flush_after_busy", 64'(busy), 64'd0);
        check("flush_after_result", result, last_res);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_op("divu_9_3", OP_DIVU, 1'b0, 64'd9, 64'd3, 0);

        mon_en  = 1'b0;
        funct3  = OP_MUL;
        is_word = 1'b0;
        src_a   = 64'hDEAD_BEEF_0000_1234;
        src_b   = 64'h0000_0000_0000_0F0F;
        start   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstmid_done", 64'(done), 64'd1);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_result", result, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        last_res = '0;
        @(negedge clk);
        check("rstmid_after_done", 64'(done), 64'd1);
        check("rstmid_after_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic        w;
            logic [63:0] a;
            logic [63:0] b;
            case ($urandom_range(0, 10))
                0, 1:    f3 = OP_MUL;
                2, 3:    f3 = OP_DIV;
                4, 5:    f3 = OP_DIVU;
                6, 7:    f3 = OP_REM;
                8, 9:    f3 = OP_REMU;
                default: f3 = 3'($urandom_range(1, 3));
            endcase
            w = 1'($urandom_range(0, 1));
            a = rand_operand(w);
            b = rand_operand(w);
            do_op($sformatf("rnd%0d", i), f3, w, a, b, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("gap_done", 64'(done), 64'd1);
                check("gap_busy", 64'(busy), 64'd0);
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
